// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus adapter: funct3 codes, FSM states,
// access sizes and byte-enable base patterns.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   // Any encoding not explicitly byte/half falls back to a full word.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction with sign/zero extension and natural-alignment check.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load,
   output logic        o_misaligned
);

   lsu_size_e   w_size;
   logic        w_signed;
   logic [31:0] w_shifted;

   assign w_size    = f3_size(i_funct3);
   assign w_signed  = ~i_funct3[2];
   assign w_shifted = i_rdata >> {i_off, 3'b000};

   always_comb begin
      o_be         = '0;
      o_wdata      = '0;
      o_load       = '0;
      o_misaligned = 1'b0;
      case (w_size)
         SZ_B: begin
            o_be    = BE_B << i_off;
            o_wdata = {4{i_store_data[7:0]}};
            o_load  = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_H: begin
            o_be         = BE_H << i_off;
            o_wdata      = {2{i_store_data[15:0]}};
            o_load       = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            o_misaligned = i_off[0];
         end
         default: begin
            o_be         = BE_W;
            o_wdata      = i_store_data;
            o_load       = i_rdata;
            o_misaligned = |i_off;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit front end: turns a CPU memory-stage access into a valid/ready
// bus request plus response wait, stalling the pipeline until completion.
module lsu_bus_adapter
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   output logic [31:0]       load_data,
   output logic              stall,
   output logic              done,
   output logic              misaligned,
   output logic              bus_error,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rsp_valid,
   input  logic [31:0]       bus_rdata
);

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   lsu_state_e        r_state;
   logic [7:0]        r_cnt;
   logic [31:0]       r_load_data;
   logic              r_req_valid;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;
   logic              r_done;
   logic              r_mis;
   logic              r_err;

   logic              w_op;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_load;
   logic              w_mis;

   assign w_op = mem_read | mem_write;

   // CPU holds funct3/addr stable while stalled, so the live inputs are still
   // valid for load extraction when the response arrives.
   lsu_align u_align (
      .i_funct3     (funct3),
      .i_off        (addr[1:0]),
      .i_store_data (store_data),
      .i_rdata      (bus_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load       (w_load),
      .o_misaligned (w_mis)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_load_data <= '0;
         r_req_valid <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_done      <= 1'b0;
         r_mis       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_mis  <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_op) begin
                  if (w_mis) begin
                     r_load_data <= '0;
                     r_done      <= 1'b1;
                     r_mis       <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_we        <= mem_write;
                     r_addr      <= {addr[ADDR_W-1:2], 2'b00};
                     r_be        <= w_be;
                     r_wdata     <= w_wdata;
                     r_req_valid <= 1'b1;
                     r_state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (bus_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus_rsp_valid) begin
                  if (!r_we) r_load_data <= w_load;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (r_cnt == LP_LAST) begin
                  r_cnt       <= r_cnt + 8'd1;
                  r_load_data <= '0;
                  r_done      <= 1'b1;
                  r_err       <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Stall is masked while reset is held so the pipeline is released at once.
   assign stall         = reset & w_op & (r_state != ST_DONE);
   assign load_data     = r_load_data;
   assign done          = r_done;
   assign misaligned    = r_mis;
   assign bus_error     = r_err;
   assign bus_req_valid = r_req_valid;
   assign bus_we        = r_we;
   assign bus_addr      = r_addr;
   assign bus_be        = r_be;
   assign bus_wdata     = r_wdata;

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit between the CPU memory stage and a wait-stated memory bus.
- Replaces the zero-latency data memory path with a valid/ready request and response handshake.
- Generates byte enables, store-data lane alignment, load sign/zero extension and misalignment detection.
- Drives a stall to freeze the PC and register-file write until the access completes.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT, 255, max cycles in WAIT before bus error; 8-bit counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  load request from control unit
- mem_write  in  1  store request from control unit
- funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU; 000/001 SB/SH
- addr  in  ADDR_W  byte address (ALU result)
- store_data  in  32  rs2 data, unaligned (value in low bits)
- load_data  out  32  extended load result; valid when done=1
- stall  out  1  hold PC/regfile; combinational
- done  out  1  one-cycle completion pulse
- misaligned  out  1  one-cycle pulse: access not naturally aligned
- bus_error  out  1  one-cycle pulse: timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_rsp_valid  in  1  response (read data or write ack)
- bus_rdata  in  32  read word

Behaviour:
- CPU holds mem_read/mem_write/funct3/addr/store_data stable while stall=1.
- mem_read and mem_write are never both 1.
- Reset values (reset=0, asynchronous): state=IDLE, load_data=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, done/misaligned/bus_error=0, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With op=mem_read|mem_write and access aligned: register bus_we, bus_addr, bus_be, bus_wdata; go to REQ.
  - With op but misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus access; go to DONE with misaligned flagged and load_data=0.
  - Without op: stay.
  - stall = op & (state!=DONE).
- REQ:
  - bus_req_valid=1.
  - Request fields must not change until bus_req_ready=1.
  - On ready: go to WAIT, clear counter.
- WAIT:
  - bus_req_valid=0. bus_rsp_valid is accepted only in WAIT; the earliest response is the cycle after acceptance.
  - On bus_rsp_valid: capture extended bus_rdata into load_data (loads only); go to DONE.
  - Otherwise increment counter. When the counter reaches TIMEOUT: go to DONE with bus_error flagged and load_data=0.
- DONE:
  - stall=0, done=1; misaligned/bus_error asserted here if flagged; go to IDLE.
  - A new op presented in the following cycle starts fresh from IDLE.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- bus_wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extraction:
  - Select the byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latency for an aligned access with immediate ready and response:
  - IDLE at N, REQ at N+1, WAIT at N+2, DONE at N+3.
  - stall high N..N+2, low N+3.
- Unsupported funct3 (011, 110, 111) is treated as word size.
- Responses arriving in IDLE/REQ/DONE are ignored. After a reset mid-operation, a late response is dropped.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the CPU reissues after reset.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef.
  - Byte-enable patterns.
- One sub-module, lsu_align: combinational byte-enable/store-lane generation and load extraction/extension. Reused by a future data cache.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ready and response immediate -> bus_be=1111, bus_wdata=0xDEADBEEF, bus_addr=0x100, stall high 3 cycles, done on 4th.
- SB addr=0x103, data=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
- LB addr=0x102, bus_rdata=0x0080FF00 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> 0x00000080.
- LW addr=0x200, bus_req_ready held 0 for 5 cycles, response 3 cycles after accept -> bus_req_valid/fields stable throughout, stall until DONE, load_data=bus_rdata.
- LW addr=0x102 -> no bus_req_valid, misaligned and done pulse together 1 cycle after op, load_data=0; LH addr=0x101 same.
- No response after accept -> bus_error and done after 255 WAIT cycles. Separate case: reset pulsed in WAIT -> stall=0, all outputs at reset values; a following bus_rsp_valid is ignored.
